// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory access path: access sizes, FSM states, lane widths.
// Also holds the latched-request layout and a saturating counter helper.
package mips_mem_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  typedef struct packed {
    logic              write;
    size_t             size;
    logic              sgn;
    logic [1:0]        offset;
    logic [WORD_W-1:0] wdata;
  } req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extract/extend a loaded lane and merge a store lane into a word.
// Purely combinational, no latency, no flow control.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [WORD_W-1:0] word_in,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        offset,
  input  size_t             size,
  input  logic              sgn,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] store_data
);

  logic [4:0]        shamt;
  logic [WORD_W-1:0] lane;
  logic [WORD_W-1:0] mask;

  always_comb begin
    shamt = {offset, 3'b000};
    lane  = word_in >> shamt;
    case (size)
      SZ_BYTE: begin
        load_data = {{(WORD_W-BYTE_W){sgn & lane[BYTE_W-1]}}, lane[BYTE_W-1:0]};
        mask      = 32'h0000_00FF << shamt;
      end
      SZ_HALF: begin
        load_data = {{(WORD_W-HALF_W){sgn & lane[HALF_W-1]}}, lane[HALF_W-1:0]};
        mask      = 32'h0000_FFFF << shamt;
      end
      default: begin
        load_data = word_in;
        mask      = '1;
      end
    endcase
    // wdata is right-aligned, so it is shifted up into the addressed lane before merging
    store_data = (word_in & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: byte/half/word loads and stores, sub-word stores via read-modify-write.
// Latency from accept: error 1, word store 2, load READ_LATENCY+1, sub-word store READ_LATENCY+2.
// Backpressure: req_ready only in IDLE, one access in flight; MEM_ACCESS_STATS_EN adds counters.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int MEM_WORDS    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [31:0] rsp_rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errors
`endif
);

  localparam logic [3:0] LAST_CNT = 4'(READ_LATENCY - 1);

  state_t            state, state_nxt;
  req_t              req_q;
  size_t             req_size_e;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept, req_err, rd_last;
  logic [31:0]       addr_nxt, wdata_nxt, rsp_rdata_nxt;
  logic              rsp_error_nxt;
  logic [WORD_W-1:0] load_data, merge_data;

  function automatic logic access_err(input logic [31:0] addr, input size_t size);
    logic bad_align;
    case (size)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = addr[0];
      SZ_WORD: bad_align = |addr[1:0];
      default: bad_align = 1'b1;
    endcase
    return bad_align || ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
  endfunction

  assign req_size_e = size_t'(req_size);
  assign accept     = req_valid && req_ready;
  assign req_err    = access_err(req_addr, req_size_e);
  assign rd_last    = (cnt == LAST_CNT);

  mem_lane_align u_align (
    .word_in    (ReadData),
    .wdata      (req_q.wdata),
    .offset     (req_q.offset),
    .size       (req_q.size),
    .sgn        (req_q.sgn),
    .load_data  (load_data),
    .store_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                               state_nxt = RESP;
          else if (req_write && req_size_e == SZ_WORD) state_nxt = WRITE;
          else                                       state_nxt = READ;
        end
      end
      READ:    if (rd_last) state_nxt = req_q.write ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; strobes follow state_nxt so they align with the state
  always_comb begin
    cnt_nxt       = 4'd0;
    addr_nxt      = Address;
    wdata_nxt     = WriteData;
    rsp_error_nxt = 1'b0;
    rsp_rdata_nxt = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          addr_nxt = {2'b00, req_addr[31:2]};
          if (req_err)                                 rsp_error_nxt = 1'b1;
          else if (req_write && req_size_e == SZ_WORD) wdata_nxt     = req_wdata;
        end
      end
      READ: begin
        cnt_nxt = cnt + 4'd1;
        if (rd_last) begin
          if (req_q.write) wdata_nxt     = merge_data;
          else             rsp_rdata_nxt = load_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Address   <= '0;
      WriteData <= '0;
    end else begin
      if (accept) begin
        req_q <= '{write: req_write, size: req_size_e, sgn: req_signed,
                   offset: req_addr[1:0], wdata: req_wdata};
      end
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      rsp_error <= rsp_error_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      MemRead   <= (state_nxt == READ);
      MemWrite  <= (state_nxt == WRITE);
      Address   <= addr_nxt;
      WriteData <= wdata_nxt;
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errors <= '0;
    end else if (rsp_valid) begin
      if (rsp_error)        stat_errors <= sat_inc16(stat_errors);
      else if (req_q.write) stat_stores <= sat_inc16(stat_stores);
      else                  stat_loads  <= sat_inc16(stat_loads);
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized traffic against a byte-array memory model.
module tb_mem_access_unit;

  localparam int LAT   = 3;
  localparam int WORDS = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

  mem_access_unit #(.READ_LATENCY(LAT), .MEM_WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_error  (rsp_error),
    .rsp_rdata  (rsp_rdata),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .WriteData  (WriteData),
    .ReadData   (ReadData)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errors (stat_errors)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide d_mem stand-in, combinational read
  logic [31:0] dmem [0:WORDS-1] = '{default: 32'h0};
  assign ReadData = (Address < WORDS) ? dmem[Address[2:0]] : 32'h0;
  always @(posedge clk) begin
    if (MemWrite && Address < WORDS) dmem[Address[2:0]] <= WriteData;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory as bytes, plus expected response fields
  logic [7:0]  rb [0:4*WORDS-1];
  logic        e_err;
  logic [31:0] e_rdata, e_wr_dat;
  int          e_rsp_k, e_rd_cnt, e_wr_cnt, e_idx;
  int          st_loads, st_stores, st_errors;

  // Observations of one access
  int          o_rsp_k, o_rd_cnt, o_rd_first, o_wr_cnt, o_wr_k;
  logic        o_err, o_timeout, o_both, o_addr_bad, o_rdy_bad, o_rdy_after;
  logic [31:0] o_rdata, o_wr_dat, o_wr_addr, o_rd_addr;

  function automatic logic [31:0] rb_word(input int idx);
    return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
  endfunction

  task automatic model_access(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd);
    int n;
    int base;
    logic [31:0] v;
    e_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
            ((a >> 2) >= WORDS);
    n        = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    e_idx    = int'(a >> 2);
    e_rdata  = 32'h0;
    e_wr_dat = 32'h0;
    e_rd_cnt = 0;
    e_wr_cnt = 0;
    if (e_err) begin
      e_rsp_k = 1;
      st_errors++;
    end else if (w) begin
      base = int'(a[4:0]);
      for (int i = 0; i < n; i++) rb[base+i] = wd[8*i +: 8];
      e_wr_dat = rb_word(e_idx);
      e_wr_cnt = 1;
      e_rd_cnt = (n == 4) ? 0 : LAT;
      e_rsp_k  = (n == 4) ? 2 : LAT + 2;
      st_stores++;
    end else begin
      base = int'(a[4:0]);
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rb[base+i];
      if (sg && n < 4)
        for (int j = 8*n; j < 32; j++) v[j] = v[8*n-1];
      e_rdata  = v;
      e_rd_cnt = LAT;
      e_rsp_k  = LAT + 1;
      st_loads++;
    end
  endtask

  // Drives one request and records what the DUT does cycle by cycle after acceptance
  task automatic run_access(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd);
    int   k;
    logic have_addr;
    logic [31:0] held_addr;
    o_rsp_k = 0; o_rd_cnt = 0; o_rd_first = 0; o_wr_cnt = 0; o_wr_k = 0;
    o_err = 1'b0; o_rdata = 32'h0; o_wr_dat = 32'h0; o_wr_addr = 32'h0; o_rd_addr = 32'h0;
    o_timeout = 1'b0; o_both = 1'b0; o_addr_bad = 1'b0; o_rdy_bad = 1'b0; o_rdy_after = 1'b0;
    have_addr = 1'b0; held_addr = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin
      o_timeout = 1'b1;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request while the access is in flight; the DUT must ignore it
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (MemRead && MemWrite) o_both = 1'b1;
      if (req_ready) o_rdy_bad = 1'b1;
      if (MemRead || MemWrite) begin
        if (have_addr && Address !== held_addr) o_addr_bad = 1'b1;
        held_addr = Address;
        have_addr = 1'b1;
      end
      if (MemRead) begin
        o_rd_cnt++;
        if (o_rd_first == 0) o_rd_first = k;
        o_rd_addr = Address;
      end
      if (MemWrite) begin
        o_wr_cnt++;
        o_wr_k    = k;
        o_wr_dat  = WriteData;
        o_wr_addr = Address;
      end
      if (rsp_valid) begin
        o_rsp_k = k;
        o_err   = rsp_error;
        o_rdata = rsp_rdata;
        break;
      end
    end
    req_valid = 1'b0;
    if (o_rsp_k == 0) begin
      o_timeout = 1'b1;
      return;
    end
    @(negedge clk);
    o_rdy_after = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_error, rsp_rdata, MemRead, MemWrite, Address, WriteData} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got %h required 0",
        {req_ready, rsp_valid, rsp_error, rsp_rdata, MemRead, MemWrite, Address, WriteData}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_word_store_load();
    model_access(1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF);
    run_access(1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF);
    n_checks++;
    if (o_timeout || o_wr_k != 1 || o_wr_addr !== 32'd3 || o_wr_dat !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL sw_strobe: to=%b wr_k=%0d addr=%h data=%h required wr_k=1 addr=3 data=deadbeef",
        o_timeout, o_wr_k, o_wr_addr, o_wr_dat); end
    n_checks++;
    if (o_rsp_k != 2 || o_err !== 1'b0 || o_rd_cnt != 0)
      begin n_fail++; $display("FAIL sw_rsp: rsp_k=%0d err=%b reads=%0d required 2 0 0", o_rsp_k, o_err, o_rd_cnt); end
    model_access(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    run_access(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    n_checks++;
    if (o_rdata !== 32'hDEADBEEF || o_rsp_k != LAT + 1)
      begin n_fail++; $display("FAIL lw_data: got %h at k=%0d required deadbeef at k=%0d", o_rdata, o_rsp_k, LAT + 1); end
  endtask

  task automatic test_lanes();
    logic [31:0] got [4];
    model_access(1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344); run_access(1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344);
    model_access(1'b1, 2'b10, 1'b0, 32'h08, 32'h80FF0000); run_access(1'b1, 2'b10, 1'b0, 32'h08, 32'h80FF0000);
    model_access(1'b0, 2'b00, 1'b1, 32'h07, 32'h0); run_access(1'b0, 2'b00, 1'b1, 32'h07, 32'h0); got[0] = o_rdata;
    model_access(1'b0, 2'b00, 1'b0, 32'h04, 32'h0); run_access(1'b0, 2'b00, 1'b0, 32'h04, 32'h0); got[1] = o_rdata;
    model_access(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0); run_access(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0); got[2] = o_rdata;
    model_access(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0); run_access(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0); got[3] = o_rdata;
    n_checks++;
    if (got[0] !== 32'h00000011) begin n_fail++; $display("FAIL lb_signed_07: got %h required 00000011", got[0]); end
    n_checks++;
    if (got[1] !== 32'h00000044) begin n_fail++; $display("FAIL lb_04: got %h required 00000044", got[1]); end
    n_checks++;
    if (got[2] !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_signed_0a: got %h required ffff80ff", got[2]); end
    n_checks++;
    if (got[3] !== 32'h000080FF) begin n_fail++; $display("FAIL lhu_0a: got %h required 000080ff", got[3]); end
  endtask

  task automatic test_rmw();
    model_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hAABBCCDD); run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hAABBCCDD);
    model_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055); run_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
    n_checks++;
    if (o_rd_cnt != LAT || o_rd_first != 1 || o_wr_cnt != 1 || o_wr_k != LAT + 1)
      begin n_fail++; $display("FAIL sb_sequence: reads=%0d first=%0d writes=%0d wr_k=%0d required %0d 1 1 %0d",
        o_rd_cnt, o_rd_first, o_wr_cnt, o_wr_k, LAT, LAT + 1); end
    n_checks++;
    if (o_wr_dat !== 32'hAABB55DD || o_wr_addr !== 32'd4)
      begin n_fail++; $display("FAIL sb_merge: got %h @%h required aabb55dd @4", o_wr_dat, o_wr_addr); end
    n_checks++;
    if (o_rsp_k != LAT + 2 || o_err !== 1'b0 || o_rdata !== 32'h0)
      begin n_fail++; $display("FAIL sb_rsp: k=%0d err=%b rdata=%h required %0d 0 0", o_rsp_k, o_err, o_rdata, LAT + 2); end
  endtask

  task automatic test_errors();
    logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] ad [4] = '{32'h02, 32'h01, 32'h00, 32'h20};
    for (int i = 0; i < 4; i++) begin
      model_access(1'b0, sz[i], 1'b0, ad[i], 32'h0);
      run_access(1'b0, sz[i], 1'b0, ad[i], 32'h0);
      n_checks++;
      if (o_timeout || o_err !== 1'b1 || o_rsp_k != 1 || (o_rd_cnt + o_wr_cnt) != 0 || o_rdata !== 32'h0)
        begin n_fail++; $display("FAIL err_case%0d: to=%b err=%b k=%0d strobes=%0d rdata=%h required err=1 k=1 strobes=0 rdata=0",
          i, o_timeout, o_err, o_rsp_k, o_rd_cnt + o_wr_cnt, o_rdata); end
    end
  endtask

  task automatic test_latency();
    model_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    n_checks++;
    if (o_rd_cnt != LAT || o_rd_first != 1 || o_rd_addr !== 32'd4 || o_addr_bad)
      begin n_fail++; $display("FAIL lat_memread: reads=%0d first=%0d addr=%h unstable=%b required %0d 1 4 0",
        o_rd_cnt, o_rd_first, o_rd_addr, o_addr_bad, LAT); end
    n_checks++;
    if (o_rdy_bad || o_rdy_after !== 1'b1)
      begin n_fail++; $display("FAIL lat_ready: busy_ready=%b after=%b required 0 1", o_rdy_bad, o_rdy_after); end
    n_checks++;
    if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL lat_data: got %h required %h", o_rdata, e_rdata); end
  endtask

  task automatic test_reset_mid_access();
    int   k;
    logic saw_wr;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h77;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (MemRead !== 1'b1) begin n_fail++; $display("FAIL abort_in_read: MemRead=%b required 1", MemRead); end
    #2 rst_n = 1'b0;
    #1;
    st_loads = 0; st_stores = 0; st_errors = 0;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_error, rsp_rdata, MemRead, MemWrite, Address, WriteData} !== '0)
      begin n_fail++; $display("FAIL abort_outputs: got %h required 0",
        {req_ready, rsp_valid, rsp_error, rsp_rdata, MemRead, MemWrite, Address, WriteData}); end
    saw_wr = 1'b0;
    repeat (3) begin @(negedge clk); if (MemWrite) saw_wr = 1'b1; end
    rst_n = 1'b1;
    repeat (8) begin @(negedge clk); if (MemWrite) saw_wr = 1'b1; end
    n_checks++;
    if (saw_wr !== 1'b0) begin n_fail++; $display("FAIL abort_no_write: saw MemWrite=%b required 0", saw_wr); end
    n_checks++;
    if (dmem[4] !== rb_word(4)) begin n_fail++; $display("FAIL abort_mem: got %h required %h", dmem[4], rb_word(4)); end
    model_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    n_checks++;
    if (o_timeout || o_rdata !== 32'hAABB55DD)
      begin n_fail++; $display("FAIL abort_recover: to=%b got %h required aabb55dd", o_timeout, o_rdata); end
  endtask

  task automatic test_random();
    logic        w, sg;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom);
      sg = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 4*WORDS + 3));
      wd = $urandom;
      model_access(w, sz, sg, a, wd);
      run_access(w, sz, sg, a, wd);
      n_checks++;
      if (o_timeout) begin n_fail++; $display("FAIL rnd%0d timeout: no response within bound", i); end
      n_checks++;
      if (o_err !== e_err || o_rsp_k != e_rsp_k)
        begin n_fail++; $display("FAIL rnd%0d rsp: err=%b k=%0d required err=%b k=%0d", i, o_err, o_rsp_k, e_err, e_rsp_k); end
      n_checks++;
      if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd%0d rdata: got %h required %h", i, o_rdata, e_rdata); end
      n_checks++;
      if (o_rd_cnt != e_rd_cnt || o_wr_cnt != e_wr_cnt)
        begin n_fail++; $display("FAIL rnd%0d strobes: reads=%0d writes=%0d required %0d %0d",
          i, o_rd_cnt, o_wr_cnt, e_rd_cnt, e_wr_cnt); end
      if (e_wr_cnt == 1) begin
        n_checks++;
        if (o_wr_dat !== e_wr_dat || o_wr_addr !== 32'(e_idx))
          begin n_fail++; $display("FAIL rnd%0d wdata: got %h @%h required %h @%h", i, o_wr_dat, o_wr_addr, e_wr_dat, 32'(e_idx)); end
      end
      n_checks++;
      if (o_both || o_addr_bad || o_rdy_bad || o_rdy_after !== 1'b1)
        begin n_fail++; $display("FAIL rnd%0d protocol: both=%b addr_moved=%b busy_ready=%b ready_after=%b required 0 0 0 1",
          i, o_both, o_addr_bad, o_rdy_bad, o_rdy_after); end
    end
  endtask

`ifdef MEM_ACCESS_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    n_checks++;
    if (stat_loads !== 16'(st_loads) || stat_stores !== 16'(st_stores) || stat_errors !== 16'(st_errors))
      begin n_fail++; $display("FAIL stats: got %0d/%0d/%0d required %0d/%0d/%0d",
        stat_loads, stat_stores, stat_errors, st_loads, st_stores, st_errors); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4*WORDS; i++) rb[i] = 8'h00;
    st_loads = 0; st_stores = 0; st_errors = 0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_word_store_load();
    test_lanes();
    test_rmw();
    test_errors();
    test_latency();
    test_reset_mid_access();
    test_random();
`ifdef MEM_ACCESS_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
